id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, directly downstream of the main decoder (Control).
- Registers the decoder's control bundle with operands, immediate, PC and register addresses for the EX stage.
- Contains load-use hazard detection: inserts a bubble into EX, holds PC and IF/ID, and arbitrates against the ID-stage branch flush.
- Keeps a saturating stall counter for performance debug.

Parameters:
DATA_W, 32, width of operands, immediate and PC
REG_AW, 5, register address width
CNT_W, 16, stall counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
RegWrite_i  in  1  decoder control
MemToReg_i  in  1  decoder control
MemRead_i  in  1  decoder control
MemWrite_i  in  1  decoder control
Branch_i  in  1  decoder control (ID-resolved branch; carried for trace only)
ALUOp_i  in  2  decoder control
ALUSrc_i  in  1  decoder control
RS1data_i / RS2data_i  in  DATA_W  register file read data
Imm_i  in  DATA_W  sign-extended immediate
PC_i  in  DATA_W  PC of ID instruction
Funct_i  in  10  {funct7, funct3}
RS1addr_i / RS2addr_i / RDaddr_i  in  REG_AW  register addresses
BranchTaken_i  in  1  ID-stage branch taken
RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Branch_o, ALUSrc_o  out  1  registered controls
ALUOp_o  out  2  registered control
RS1data_o, RS2data_o, Imm_o, PC_o  out  DATA_W  registered data
Funct_o  out  10  registered funct
RS1addr_o, RS2addr_o, RDaddr_o  out  REG_AW  registered addresses (to forwarding unit)
Stall_o  out  1  load-use hazard; comb.
PCWrite_o  out  1  = ~Stall_o
IFIDWrite_o  out  1  = ~Stall_o
IFIDFlush_o  out  1  = BranchTaken_i & ~Stall_o
StallCnt_o  out  CNT_W  stall cycle count

Behaviour:
- Reset (async, rst_i=1): every registered output is 0, including StallCnt_o. Stall_o is 0 (RDaddr_o=0 and MemRead_o=0).
- Hazard, combinational on the current EX contents: hazard = MemRead_o & (RDaddr_o != 0) & ((RDaddr_o == RS1addr_i) | (RDaddr_o == RS2addr_i)).
  - Comparison is conservative: RS2 is compared even for I-type instructions.
- Stall_o = hazard.
- Each rising clock edge:
  - Stall_o=1: load a bubble. All control outputs go to 0 (RegWrite, MemToReg, MemRead, MemWrite, Branch, ALUSrc, ALUOp=00), and RDaddr_o goes to 0.
    - Data, Imm, PC, Funct and RS addresses are loaded normally. They are don't-care under a bubble.
  - BranchTaken_i=1 and Stall_o=0: load the branch instruction normally. Branch has no EX side effects. IFIDFlush_o kills the wrong-path instruction in IF/ID.
  - Otherwise: capture all inputs, latency 1 cycle.
- Stall beats flush. While stalled, BranchTaken_i is ignored (IFIDFlush_o=0). The branch is re-evaluated in ID next cycle with the correct operand.
- A load-use stall lasts exactly 1 cycle: after the bubble, MemRead_o=0, so hazard deasserts.
- Back-to-back loads with a dependency stall once per dependent pair.
- StallCnt_o increments by 1 on each clock edge with Stall_o=1. It saturates at 2^CNT_W-1 and does not wrap.
- Reset mid-stall: outputs clear immediately (async), and the stall drops the same instant.
- x0 is never a hazard source.

Test Plan:
- Reset: assert rst_i mid-cycle with outputs nonzero -> all outputs 0 immediately, StallCnt_o=0, PCWrite_o=1.
- Plain pass-through: R-type (RegWrite_i=1, ALUOp_i=10, RS1data_i=0x11, RDaddr_i=5), no hazard -> next edge RegWrite_o=1, ALUOp_o=10, RS1data_o=0x11, RDaddr_o=5.
- Load-use stall: EX holds lw with RDaddr_o=7 and MemRead_o=1, ID has RS2addr_i=7 -> Stall_o=1, PCWrite_o=0, IFIDWrite_o=0. Next edge all controls 0 and RDaddr_o=0, StallCnt_o=1. Following cycle Stall_o=0.
- x0 exemption: EX lw with RDaddr_o=0, ID RS1addr_i=0 -> Stall_o=0, normal capture.
- Stall vs flush: hazard present and BranchTaken_i=1 -> IFIDFlush_o=0, bubble inserted. Next cycle BranchTaken_i=1, no hazard -> IFIDFlush_o=1, Branch_o=1 after the edge.
- Saturation with CNT_W=2: force 5 consecutive hazard cycles -> StallCnt_o sequence 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decoder-to-EX bundle for the ID/EX pipeline register, plus the hazard/flush
// controls returned to the fetch side.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              RegWrite_i;
    logic              MemToReg_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic              Branch_i;
    logic [1:0]        ALUOp_i;
    logic              ALUSrc_i;
    logic [DATA_W-1:0] RS1data_i;
    logic [DATA_W-1:0] RS2data_i;
    logic [DATA_W-1:0] Imm_i;
    logic [DATA_W-1:0] PC_i;
    logic [9:0]        Funct_i;
    logic [REG_AW-1:0] RS1addr_i;
    logic [REG_AW-1:0] RS2addr_i;
    logic [REG_AW-1:0] RDaddr_i;
    logic              BranchTaken_i;

    logic              RegWrite_o;
    logic              MemToReg_o;
    logic              MemRead_o;
    logic              MemWrite_o;
    logic              Branch_o;
    logic              ALUSrc_o;
    logic [1:0]        ALUOp_o;
    logic [DATA_W-1:0] RS1data_o;
    logic [DATA_W-1:0] RS2data_o;
    logic [DATA_W-1:0] Imm_o;
    logic [DATA_W-1:0] PC_o;
    logic [9:0]        Funct_o;
    logic [REG_AW-1:0] RS1addr_o;
    logic [REG_AW-1:0] RS2addr_o;
    logic [REG_AW-1:0] RDaddr_o;
    logic              Stall_o;
    logic              PCWrite_o;
    logic              IFIDWrite_o;
    logic              IFIDFlush_o;
    logic [CNT_W-1:0]  StallCnt_o;

    // Decoder / fetch side.
    modport master (
        output RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, Branch_i, ALUOp_i, ALUSrc_i,
               RS1data_i, RS2data_i, Imm_i, PC_i, Funct_i,
               RS1addr_i, RS2addr_i, RDaddr_i, BranchTaken_i,
        input  RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Branch_o, ALUSrc_o, ALUOp_o,
               RS1data_o, RS2data_o, Imm_o, PC_o, Funct_o,
               RS1addr_o, RS2addr_o, RDaddr_o,
               Stall_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, StallCnt_o
    );

    // Pipeline register side.
    modport slave (
        input  RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, Branch_i, ALUOp_i, ALUSrc_i,
               RS1data_i, RS2data_i, Imm_i, PC_i, Funct_i,
               RS1addr_i, RS2addr_i, RDaddr_i, BranchTaken_i,
        output RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Branch_o, ALUSrc_o, ALUOp_o,
               RS1data_o, RS2data_o, Imm_o, PC_o, Funct_o,
               RS1addr_o, RS2addr_o, RDaddr_o,
               Stall_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, StallCnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush
// arbitration and a saturating stall-cycle counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    id_ex_stage_if.slave bus
);
    logic              regWriteQ;
    logic              memToRegQ;
    logic              memReadQ;
    logic              memWriteQ;
    logic              branchQ;
    logic              aluSrcQ;
    logic [1:0]        aluOpQ;
    logic [DATA_W-1:0] rs1DataQ;
    logic [DATA_W-1:0] rs2DataQ;
    logic [DATA_W-1:0] immQ;
    logic [DATA_W-1:0] pcQ;
    logic [9:0]        functQ;
    logic [REG_AW-1:0] rs1AddrQ;
    logic [REG_AW-1:0] rs2AddrQ;
    logic [REG_AW-1:0] rdAddrQ;
    logic [CNT_W-1:0]  stallCntQ;
    logic              hazard;
    logic              rdMatch;

    // RS2 is compared even for I-type; a spurious stall costs one cycle, a missed one corrupts data.
    assign rdMatch = (rdAddrQ == bus.RS1addr_i) | (rdAddrQ == bus.RS2addr_i);
    assign hazard  = memReadQ & (rdAddrQ != '0) & rdMatch;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regWriteQ <= 1'b0;
            memToRegQ <= 1'b0;
            memReadQ  <= 1'b0;
            memWriteQ <= 1'b0;
            branchQ   <= 1'b0;
            aluSrcQ   <= 1'b0;
            aluOpQ    <= '0;
            rdAddrQ   <= '0;
        end else if (hazard) begin
            regWriteQ <= 1'b0;
            memToRegQ <= 1'b0;
            memReadQ  <= 1'b0;
            memWriteQ <= 1'b0;
            branchQ   <= 1'b0;
            aluSrcQ   <= 1'b0;
            aluOpQ    <= '0;
            rdAddrQ   <= '0;
        end else begin
            regWriteQ <= bus.RegWrite_i;
            memToRegQ <= bus.MemToReg_i;
            memReadQ  <= bus.MemRead_i;
            memWriteQ <= bus.MemWrite_i;
            branchQ   <= bus.Branch_i;
            aluSrcQ   <= bus.ALUSrc_i;
            aluOpQ    <= bus.ALUOp_i;
            rdAddrQ   <= bus.RDaddr_i;
        end
    end

    // Payload is captured every cycle; under a bubble it is simply ignored downstream.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rs1DataQ <= '0;
            rs2DataQ <= '0;
            immQ     <= '0;
            pcQ      <= '0;
            functQ   <= '0;
            rs1AddrQ <= '0;
            rs2AddrQ <= '0;
        end else begin
            rs1DataQ <= bus.RS1data_i;
            rs2DataQ <= bus.RS2data_i;
            immQ     <= bus.Imm_i;
            pcQ      <= bus.PC_i;
            functQ   <= bus.Funct_i;
            rs1AddrQ <= bus.RS1addr_i;
            rs2AddrQ <= bus.RS2addr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stallCntQ <= '0;
        end else if (hazard && (stallCntQ != '1)) begin
            stallCntQ <= stallCntQ + CNT_W'(1);
        end
    end

    assign bus.RegWrite_o  = regWriteQ;
    assign bus.MemToReg_o  = memToRegQ;
    assign bus.MemRead_o   = memReadQ;
    assign bus.MemWrite_o  = memWriteQ;
    assign bus.Branch_o    = branchQ;
    assign bus.ALUSrc_o    = aluSrcQ;
    assign bus.ALUOp_o     = aluOpQ;
    assign bus.RS1data_o   = rs1DataQ;
    assign bus.RS2data_o   = rs2DataQ;
    assign bus.Imm_o       = immQ;
    assign bus.PC_o        = pcQ;
    assign bus.Funct_o     = functQ;
    assign bus.RS1addr_o   = rs1AddrQ;
    assign bus.RS2addr_o   = rs2AddrQ;
    assign bus.RDaddr_o    = rdAddrQ;
    assign bus.StallCnt_o  = stallCntQ;

    // Stall beats flush: the branch is re-resolved next cycle with the loaded operand.
    assign bus.Stall_o     = hazard;
    assign bus.PCWrite_o   = ~hazard;
    assign bus.IFIDWrite_o = ~hazard;
    assign bus.IFIDFlush_o = bus.BranchTaken_i & ~hazard;
endmodule
